// File: rtl/frv_alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: op-strobe bit indices, branch codes,
// occupancy states and the branch-condition resolver.
package frv_alu_issue_pkg;

  localparam int ALU_OP_W        = 10;
  localparam int ALU_OP_ADD      = 0;
  localparam int ALU_OP_SUB      = 1;
  localparam int ALU_OP_XOR      = 2;
  localparam int ALU_OP_OR       = 3;
  localparam int ALU_OP_AND      = 4;
  localparam int ALU_OP_SHF      = 5;
  localparam int ALU_OP_SHF_LEFT = 6;
  localparam int ALU_OP_SHF_ARI  = 7;
  localparam int ALU_OP_CMP      = 8;
  localparam int ALU_OP_UNSIGNED = 9;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_EQ   = 3'b001;
  localparam logic [2:0] BR_NE   = 3'b010;
  localparam logic [2:0] BR_LT   = 3'b100;
  localparam logic [2:0] BR_GE   = 3'b101;

  // Encoding is {iss_v, res_v}, so the state bits are the stage valid flags.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_RES   = 2'b01,
    OCC_ISS   = 2'b10,
    OCC_BOTH  = 2'b11
  } occ_e;

  // Signed/unsigned ordering is already folded into lt by the ALU peer.
  function automatic logic br_resolve(input logic [2:0] br, input logic lt, input logic eq);
    logic taken;
    taken = 1'b0;
    case (br)
      BR_EQ:   taken = eq;
      BR_NE:   taken = !eq;
      BR_LT:   taken = lt;
      BR_GE:   taken = !lt;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/frv_pipe_reg.sv
// Payload half of a valid/ready register slice: loads on demand, holds otherwise.
// The matching valid flag lives in the owner's occupancy state machine.
module frv_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/frv_alu_issue.sv
// Execute-stage initiator: ISS slice drives the ALU peer, RES slice holds
// {rd, result, branch taken} for writeback. Two entries, full throughput.
module frv_alu_issue
  import frv_alu_issue_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic                g_clk,
  input  logic                g_reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [ALU_OP_W-1:0] s_op,
  input  logic [2:0]          s_br,
  input  logic [RD_W-1:0]     s_rd,
  input  logic [XLEN-1:0]     s_lhs,
  input  logic [XLEN-1:0]     s_rhs,
  input  logic                flush,
  output logic                alu_valid,
  output logic                alu_flush,
  input  logic                alu_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [XLEN-1:0]     alu_lhs,
  output logic [XLEN-1:0]     alu_rhs,
  input  logic [XLEN-1:0]     alu_result,
  input  logic                alu_lt,
  input  logic                alu_eq,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [RD_W-1:0]     m_rd,
  output logic [XLEN-1:0]     m_result,
  output logic                m_br_taken
);

  localparam int ISS_W = ALU_OP_W + 3 + RD_W + 2 * XLEN;
  localparam int RES_W = RD_W + XLEN + 1;

  occ_e state_reg;
  occ_e state_next;

  logic              iss_v;
  logic              res_v;
  logic              adv;
  logic              accept;
  logic              m_fire;
  logic              iss_next;
  logic              res_next;
  logic              res_load;

  logic [ALU_OP_W-1:0] iss_op;
  logic [2:0]          iss_br;
  logic [RD_W-1:0]     iss_rd;
  logic [ISS_W-1:0]    iss_q;
  logic [RES_W-1:0]    res_q;

  assign iss_v = state_reg[1];
  assign res_v = state_reg[0];

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_reg <= OCC_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    adv        = iss_v && alu_ready && (!res_v || m_ready);
    s_ready    = !flush && (!iss_v || adv);
    accept     = s_valid && s_ready;
    m_valid    = res_v && !flush;
    m_fire     = m_valid && m_ready;
    res_load   = adv && !flush;
    iss_next   = accept || (iss_v && !adv);
    res_next   = adv || (res_v && !m_fire);
    if (flush) begin
      iss_next = 1'b0;
      res_next = 1'b0;
    end
    state_next = occ_e'({iss_next, res_next});
  end

  // ISS only reloads on accept, so the ALU inputs stay frozen across stalls.
  frv_pipe_reg #(.W(ISS_W)) u_iss (
    .clk  (g_clk),
    .srst (g_reset),
    .load (accept),
    .d    ({s_op, s_br, s_rd, s_lhs, s_rhs}),
    .q    (iss_q)
  );

  assign {iss_op, iss_br, iss_rd, alu_lhs, alu_rhs} = iss_q;

  frv_pipe_reg #(.W(RES_W)) u_res (
    .clk  (g_clk),
    .srst (g_reset),
    .load (res_load),
    .d    ({iss_rd, alu_result, br_resolve(iss_br, alu_lt, alu_eq)}),
    .q    (res_q)
  );

  assign {m_rd, m_result, m_br_taken} = res_q;

  assign alu_valid = iss_v;
  assign alu_flush = flush;
  assign alu_op    = iss_v ? iss_op : '0;

endmodule
